// File: rtl/fft_pkg.sv
// Shared constants and arithmetic helpers for the FFT datapath blocks.
// Helpers work on 64-bit signed values; callers size-cast the results back down.
package fft_pkg;

    localparam int DW_DEF = 16;
    localparam int TW_DEF = 16;

    typedef enum logic {
        MODE_DIT = 1'b0,
        MODE_DIF = 1'b1
    } mode_e;

    // Arithmetic shift right by sh (>= 1) with round half-up.
    function automatic logic signed [63:0] rnd_shr(input logic signed [63:0] x, input int sh);
        logic signed [63:0] half;
        half = 64'sd1 <<< (sh - 1);
        return (x + half) >>> sh;
    endfunction

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic logic sat_hit(input logic signed [63:0] x, input int w);
        return (x > sat_max(w)) || (x < sat_min(w));
    endfunction

    function automatic logic signed [63:0] sat_val(input logic signed [63:0] x, input int w);
        if (x > sat_max(w)) begin
            return sat_max(w);
        end else if (x < sat_min(w)) begin
            return sat_min(w);
        end
        return x;
    endfunction

endpackage

// File: rtl/butterfly_pipe_cmul.sv
// Registered complex multiplier: p = a * w, products rounded half-up back to
// the operand scale. Output grows by two bits so no magnitude is lost.
module cmul
    import fft_pkg::*;
#(
    parameter int AW = DW_DEF + 1,
    parameter int TW = TW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic signed [AW-1:0] a_re,
    input  logic signed [AW-1:0] a_im,
    input  logic signed [TW-1:0] w_re,
    input  logic signed [TW-1:0] w_im,
    output logic signed [AW+1:0] p_re,
    output logic signed [AW+1:0] p_im
);

    localparam int PW = AW + TW;

    logic signed [PW-1:0] rr, ii, ri, ir;
    logic signed [PW:0]   sum_re, sum_im;

    always_comb begin
        rr     = PW'(a_re) * PW'(w_re);
        ii     = PW'(a_im) * PW'(w_im);
        ri     = PW'(a_re) * PW'(w_im);
        ir     = PW'(a_im) * PW'(w_re);
        sum_re = (PW + 1)'(rr) - (PW + 1)'(ii);
        sum_im = (PW + 1)'(ri) + (PW + 1)'(ir);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_re <= '0;
            p_im <= '0;
        end else if (en) begin
            p_re <= (AW + 2)'(rnd_shr(64'(sum_re), TW - 1));
            p_im <= (AW + 2)'(rnd_shr(64'(sum_im), TW - 1));
        end
    end

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 butterfly (DIT or DIF per transfer) with global stall.
// An input presented in cycle n is on the outputs in cycle n+3 when not stalled.
module butterfly_pipe
    import fft_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] xa_re,
    input  logic signed [DW-1:0] xa_im,
    input  logic signed [DW-1:0] xb_re,
    input  logic signed [DW-1:0] xb_im,
    input  logic signed [TW-1:0] w_re,
    input  logic signed [TW-1:0] w_im,
    input  logic                 mode,
    input  logic                 scale,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] ya_re,
    output logic signed [DW-1:0] ya_im,
    output logic signed [DW-1:0] yb_re,
    output logic signed [DW-1:0] yb_im,
    output logic                 ovf,
    input  logic                 clr_ovf
);

    localparam int IW = DW + 3;
    localparam int MW = DW + 1;

    logic adv;
    assign in_ready = !out_valid || out_ready;
    assign adv      = in_ready;

    // S1: u is the operand that bypasses the multiplier, m the one that is multiplied
    logic signed [IW-1:0] s1n_u_re, s1n_u_im;
    logic signed [MW-1:0] s1n_m_re, s1n_m_im;

    always_comb begin
        if (mode == MODE_DIF) begin
            s1n_u_re = IW'(xa_re) + IW'(xb_re);
            s1n_u_im = IW'(xa_im) + IW'(xb_im);
            s1n_m_re = MW'(xa_re) - MW'(xb_re);
            s1n_m_im = MW'(xa_im) - MW'(xb_im);
        end else begin
            s1n_u_re = IW'(xa_re);
            s1n_u_im = IW'(xa_im);
            s1n_m_re = MW'(xb_re);
            s1n_m_im = MW'(xb_im);
        end
    end

    logic                 s1_valid, s1_scale;
    mode_e                s1_mode;
    logic signed [IW-1:0] s1_u_re, s1_u_im;
    logic signed [MW-1:0] s1_m_re, s1_m_im;
    logic signed [TW-1:0] s1_w_re, s1_w_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_scale <= 1'b0;
            s1_mode  <= MODE_DIT;
            s1_u_re  <= '0;
            s1_u_im  <= '0;
            s1_m_re  <= '0;
            s1_m_im  <= '0;
            s1_w_re  <= '0;
            s1_w_im  <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_scale <= scale;
                s1_mode  <= mode_e'(mode);
                s1_u_re  <= s1n_u_re;
                s1_u_im  <= s1n_u_im;
                s1_m_re  <= s1n_m_re;
                s1_m_im  <= s1n_m_im;
                s1_w_re  <= w_re;
                s1_w_im  <= w_im;
            end
        end
    end

    // S2: product from cmul, bypass operand and controls delayed alongside
    logic signed [IW-1:0] p_re, p_im;

    cmul #(
        .AW (MW),
        .TW (TW)
    ) u_cmul (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (adv),
        .a_re  (s1_m_re),
        .a_im  (s1_m_im),
        .w_re  (s1_w_re),
        .w_im  (s1_w_im),
        .p_re  (p_re),
        .p_im  (p_im)
    );

    logic                 s2_valid, s2_scale;
    mode_e                s2_mode;
    logic signed [IW-1:0] s2_u_re, s2_u_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_scale <= 1'b0;
            s2_mode  <= MODE_DIT;
            s2_u_re  <= '0;
            s2_u_im  <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_scale <= s1_scale;
            s2_mode  <= s1_mode;
            s2_u_re  <= s1_u_re;
            s2_u_im  <= s1_u_im;
        end
    end

    // S3: post add/sub, optional halving, saturation
    logic signed [IW-1:0] pre [4];
    logic signed [63:0]   sc  [4];
    logic signed [DW-1:0] yn  [4];
    logic [3:0]           hit;

    always_comb begin
        if (s2_mode == MODE_DIF) begin
            pre[0] = s2_u_re;
            pre[1] = s2_u_im;
            pre[2] = p_re;
            pre[3] = p_im;
        end else begin
            pre[0] = s2_u_re + p_re;
            pre[1] = s2_u_im + p_im;
            pre[2] = s2_u_re - p_re;
            pre[3] = s2_u_im - p_im;
        end
        for (int i = 0; i < 4; i++) begin
            sc[i]  = s2_scale ? rnd_shr(64'(pre[i]), 1) : 64'(pre[i]);
            hit[i] = sat_hit(sc[i], DW);
            yn[i]  = DW'(sat_val(sc[i], DW));
        end
    end

    logic ovf_set;
    assign ovf_set = adv && s2_valid && (|hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ya_re     <= '0;
            ya_im     <= '0;
            yb_re     <= '0;
            yb_im     <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                ya_re <= yn[0];
                ya_im <= yn[1];
                yb_re <= yn[2];
                yb_im <= yn[3];
            end
        end
    end

    // A saturation landing in the same cycle as a clear must not be lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe: scoreboard of reference results pushed
// on input transfer, popped and compared on output transfer.
module tb_butterfly_pipe;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] xa_re = '0, xa_im = '0, xb_re = '0, xb_im = '0;
    logic signed [15:0] w_re = '0, w_im = '0;
    logic               mode = 1'b0, scale = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] ya_re, ya_im, yb_re, yb_im;
    logic               ovf;
    logic               clr_ovf = 1'b0;

    butterfly_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .xa_re     (xa_re),
        .xa_im     (xa_im),
        .xb_re     (xb_re),
        .xb_im     (xb_im),
        .w_re      (w_re),
        .w_im      (w_im),
        .mode      (mode),
        .scale     (scale),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ya_re     (ya_re),
        .ya_im     (ya_im),
        .yb_re     (yb_re),
        .yb_im     (yb_im),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] y;
        bit          sat;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp;
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic longint clip(input longint x, inout bit s);
        if (x > 32767) begin
            s = 1'b1;
            return 32767;
        end
        if (x < -32768) begin
            s = 1'b1;
            return -32768;
        end
        return x;
    endfunction

    // Reference butterfly, DW = TW = 16
    function automatic exp_t model(input int ar, ai, br, bi, wr, wi, input bit md, sc);
        longint ur, ui, mr, mi, pr, pi;
        longint y[4];
        bit     s;
        exp_t   r;
        if (md) begin
            ur = ar + br; ui = ai + bi; mr = ar - br; mi = ai - bi;
        end else begin
            ur = ar; ui = ai; mr = br; mi = bi;
        end
        pr = (mr * wr - mi * wi + 16384) >>> 15;
        pi = (mr * wi + mi * wr + 16384) >>> 15;
        if (md) begin
            y[0] = ur; y[1] = ui; y[2] = pr; y[3] = pi;
        end else begin
            y[0] = ur + pr; y[1] = ui + pi; y[2] = ur - pr; y[3] = ui - pi;
        end
        s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (sc) y[i] = (y[i] + 1) >>> 1;
            y[i] = clip(y[i], s);
        end
        r.y   = {y[0][15:0], y[1][15:0], y[2][15:0], y[3][15:0]};
        r.sat = s;
        return r;
    endfunction

    task automatic set_in(input int ar, ai, br, bi, wr, wi, input bit md, sc);
        xa_re = 16'(ar); xa_im = 16'(ai);
        xb_re = 16'(br); xb_im = 16'(bi);
        w_re  = 16'(wr); w_im  = 16'(wi);
        mode  = md;      scale = sc;
        cur_exp = model(ar, ai, br, bi, wr, wi, md, sc);
    endtask

    // Presents one vector, pushes its expectation on acceptance, returns 1 ns after the accepting edge
    task automatic send_one(input int ar, ai, br, bi, wr, wi, input bit md, sc);
        int tries;
        @(negedge clk);
        set_in(ar, ai, br, bi, wr, wi, md, sc);
        in_valid = 1'b1;
        #1;
        tries = 0;
        while (!in_ready && tries < 20) begin
            @(negedge clk);
            #1;
            tries++;
        end
        n_cmp++;
        if (!in_ready) begin
            n_err++;
            $display("FAIL send_timeout in_ready=%b required=1", in_ready);
        end
        exp_q.push_back(cur_exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_negedges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr;
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl out_valid=%b in_ready=%b ovf=%b required 0/1/0", out_valid, in_ready, ovf);
        end
        n_cmp++;
        if ({ya_re, ya_im, yb_re, yb_im} !== 64'h0) begin
            n_err++;
            $display("FAIL reset_data got=%h required=0", {ya_re, ya_im, yb_re, yb_im});
        end
        wait_negedges(2);
        rst_n = 1'b1;
        wait_negedges(2);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_idle out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    // Checks the 3-cycle latency and the result of the single vector in flight
    task automatic test_dit(input bit sc);
        logic [63:0] req;
        out_ready = 1'b1;
        pulse_clr();
        send_one(1, 0, 3, 0, 32767, 0, 1'b0, sc);
        req = sc ? {16'sd2, 16'sd0, -16'sd1, 16'sd0} : {16'sd4, 16'sd0, -16'sd2, 16'sd0};
        wait_negedges(2);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL dit_early_valid scale=%0d out_valid=%b required=0", sc, out_valid);
        end
        wait_negedges(1);
        e = exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || {ya_re, ya_im, yb_re, yb_im} !== e.y || e.y !== req) begin
            n_err++;
            $display("FAIL dit scale=%0d valid=%b got=%h required=%h", sc, out_valid, {ya_re, ya_im, yb_re, yb_im}, req);
        end
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL dit_ovf got=%b required=0", ovf);
        end
    endtask

    task automatic test_dif;
        logic [63:0] req;
        send_one(100, 50, 20, 10, 0, 32767, 1'b1, 1'b0);
        req = {16'sd120, 16'sd60, -16'sd40, 16'sd80};
        wait_negedges(3);
        e = exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || {ya_re, ya_im, yb_re, yb_im} !== req || e.y !== req) begin
            n_err++;
            $display("FAIL dif valid=%b got=%h required=%h", out_valid, {ya_re, ya_im, yb_re, yb_im}, req);
        end
    endtask

    task automatic test_ovf;
        send_one(32767, 32767, 32767, 32767, 32767, 0, 1'b0, 1'b0);
        wait_negedges(3);
        e = exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || {ya_re, ya_im, yb_re, yb_im} !== {16'sd32767, 16'sd32767, 16'sd1, 16'sd1}) begin
            n_err++;
            $display("FAIL ovf_sat_data got=%h required=%h", {ya_re, ya_im, yb_re, yb_im}, {16'sd32767, 16'sd32767, 16'sd1, 16'sd1});
        end
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set got=%b required=1", ovf);
        end
        pulse_clr();
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear got=%b required=0", ovf);
        end
        // a = b = -1.0, W = -1.0; clear asserted on the edge the saturated result lands
        send_one(-32768, -32768, -32768, -32768, -32768, 0, 1'b0, 1'b0);
        wait_negedges(2);
        clr_ovf = 1'b1;
        wait_negedges(1);
        clr_ovf = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if ({ya_re, ya_im, yb_re, yb_im} !== e.y || e.sat !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_boundary_data got=%h required=%h", {ya_re, ya_im, yb_re, yb_im}, e.y);
        end
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set_beats_clr got=%b required=1", ovf);
        end
    endtask

    task automatic test_stream;
        localparam int N = 16;
        int          vec[N][6];
        bit          vmd[N], vsc[N];
        int          sent, got, cyc;
        bit          held_pend;
        logic [63:0] held;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < 6; j++) vec[i][j] = int'($urandom_range(0, 65535)) - 32768;
            vmd[i] = 1'($urandom_range(0, 1));
            vsc[i] = 1'($urandom_range(0, 1));
        end
        exp_q.delete();
        sent = 0; got = 0; cyc = 0; held_pend = 1'b0; held = '0;
        while (got < N && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (held_pend) begin
                n_cmp++;
                if (out_valid !== 1'b1 || {ya_re, ya_im, yb_re, yb_im} !== held) begin
                    n_err++;
                    $display("FAIL stall_hold valid=%b got=%h required=%h", out_valid, {ya_re, ya_im, yb_re, yb_im}, held);
                end
                held_pend = 1'b0;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if (sent < N) begin
                set_in(vec[sent][0], vec[sent][1], vec[sent][2], vec[sent][3], vec[sent][4], vec[sent][5], vmd[sent], vsc[sent]);
                in_valid = (sent < 8) || ($urandom_range(0, 3) != 0);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL stream_extra got=%h required=none", {ya_re, ya_im, yb_re, yb_im});
                end else begin
                    e = exp_q.pop_front();
                    if ({ya_re, ya_im, yb_re, yb_im} !== e.y) begin
                        n_err++;
                        $display("FAIL stream_data idx=%0d got=%h required=%h", got, {ya_re, ya_im, yb_re, yb_im}, e.y);
                    end
                end
                got++;
            end else if (out_valid) begin
                held = {ya_re, ya_im, yb_re, yb_im};
                held_pend = 1'b1;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_exp);
                sent++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (got != N || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL stream_count got=%0d pending=%0d required=%0d/0", got, exp_q.size(), N);
        end
    endtask

    task automatic test_reset_flight;
        out_ready = 1'b1;
        @(negedge clk);
        set_in(1000, -2000, 300, 400, 12000, -5000, 1'b0, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        set_in(-700, 800, 900, -100, -3000, 20000, 1'b1, 1'b1);
        @(negedge clk);
        set_in(5, 6, 7, 8, 32767, 0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf !== 1'b0 || {ya_re, ya_im, yb_re, yb_im} !== 64'h0) begin
            n_err++;
            $display("FAIL flight_reset valid=%b ready=%b ovf=%b data=%h required 0/1/0/0", out_valid, in_ready, ovf, {ya_re, ya_im, yb_re, yb_im});
        end
        in_valid = 1'b0;
        wait_negedges(2);
        rst_n = 1'b1;
        exp_q.delete();
        send_one(-1234, 567, 890, -321, 23170, -23170, 1'b0, 1'b1);
        wait_negedges(2);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flight_stale valid=%b required=0", out_valid);
        end
        wait_negedges(1);
        e = exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || {ya_re, ya_im, yb_re, yb_im} !== e.y) begin
            n_err++;
            $display("FAIL flight_after_reset valid=%b got=%h required=%h", out_valid, {ya_re, ya_im, yb_re, yb_im}, e.y);
        end
    endtask

    initial begin
        test_reset();
        test_dit(1'b0);
        test_dit(1'b1);
        test_dif();
        test_ovf();
        test_stream();
        test_reset_flight();
        wait_negedges(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
